rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the single register-file write port between the pipeline MEM/WB writeback
//  and the multi-cycle long-latency unit (LLU: MUL/DIV). LLU results are buffered in a
//  small FIFO. The WB path wins by default; an aging counter prevents LLU starvation by
//  holding WB for one cycle. Emits read/write bypass flags and a pending-write mask for
//  the hazard unit.
// PARAMETERS
//  DATA_W        64  register data width
//  DEPTH          2  LLU result FIFO entries (power of two, >=2)
//  STARVE_LIMIT   4  cycles FIFO head may lose arbitration before forced grant (>=1)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       asynchronous, active-low reset
//  wb_regwrite    in   1       MEM/WB stage requests a register write this cycle
//  wb_rd          in   5       MEM/WB destination register
//  wb_data        in   DATA_W  MEM/WB write data
//  wb_hold        out  1       WB write not taken this cycle; MEM/WB and upstream freeze, retry next cycle
//  llu_valid      in   1       LLU result available
//  llu_rd         in   5       LLU destination register
//  llu_data       in   DATA_W  LLU result data
//  llu_ready      out  1       FIFO can accept; transfer on llu_valid & llu_ready
//  rf_we          out  1       register-file write enable
//  rf_waddr       out  5       register-file write address
//  rf_wdata       out  DATA_W  register-file write data
//  rf_wsrc        out  1       0 = WB granted, 1 = FIFO head granted
//  Rn, Rm         in   5       register-file read addresses (ID stage)
//  readwrite1     out  1       rf write this cycle targets Rn (bypass read port 1)
//  readwrite2     out  1       rf write this cycle targets Rm (bypass read port 2)
//  llu_pending    out  32      bit r set when any valid FIFO entry targets register r
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, pointers 0, starve counter 0.
//    All outputs are combinational from state and inputs. Under reset: rf_we=0,
//    wb_hold=0, llu_ready=1, llu_pending=0, readwrite1/2=0.
//  - XZR: rd==31 is never written. wb_regwrite with wb_rd==31 is a no-op request and
//    never asserts wb_hold. LLU result with rd==31 is accepted (llu_ready honoured) but
//    not enqueued.
//  - llu_ready = (count < DEPTH); a same-cycle pop is not credited. Accept at edge t
//    makes the entry visible at t+1. Earliest write is cycle t+1, so LLU latency is 1.
//  - Arbitration each cycle. wb_req = wb_regwrite & wb_rd!=31; q_req = FIFO not empty.
//    * q_req only: grant FIFO head, pop at edge.
//    * wb_req only: grant WB.
//    * both, starve_cnt < STARVE_LIMIT: grant WB, starve_cnt++.
//    * both, starve_cnt == STARVE_LIMIT: grant FIFO head, wb_hold=1, pop.
//    * starve_cnt clears to 0 on every pop and whenever FIFO is empty.
//  - rf_we = grant issued; rf_waddr/rf_wdata/rf_wsrc come from the granted source.
//    When idle: rf_we=0, waddr/wdata=0, wsrc=0.
//  - readwrite1 = rf_we & rf_waddr==Rn; readwrite2 = rf_we & rf_waddr==Rm
//    (both 0 for rd 31, since rf_we=0 then).
//  - llu_pending: OR over valid entries of onehot(rd), updated at edge.
//    A popped entry clears its bit in the same edge unless another valid entry has the
//    same rd. WAW ordering against WB is the hazard unit's job, using llu_pending.
//  - Simultaneous push and pop when full: no push (llu_ready=0). When not full, both
//    occur and count is unchanged. Pointers wrap modulo DEPTH.
//  - Reset mid-operation: buffered entries are discarded immediately, with no write
//    issued.
// TESTING
//  1 Reset low with FIFO holding 2 entries -> immediately rf_we=0, llu_pending=0,
//    llu_ready=1. Release -> idle.
//  2 Idle WB; LLU rd=5 data=0xAA accepted at t -> t+1: rf_we=1 waddr=5 wdata=0xAA
//    wsrc=1, llu_pending[5]=1. t+2: llu_pending=0.
//  3 WB writes rd=3 every cycle; LLU rd=7 enqueued -> WB granted 4 cycles, 5th cycle
//    wsrc=1 waddr=7 wb_hold=1, next cycle WB rd=3 retried and granted.
//  4 WB busy; push rd=1, rd=2 -> llu_ready=0 with third llu_valid held; no accept until
//    forced pop, then drain order is rd=1 then rd=2.
//  5 wb_regwrite rd=31 plus LLU rd=31 -> rf_we=0, wb_hold=0, llu_pending=0,
//    readwrite1/2=0.
//  6 WB write rd=9, Rn=9, Rm=4 -> readwrite1=1, readwrite2=0. Rn=Rm=9 -> both 1.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: MEM/WB writeback versus a small FIFO of
// long-latency-unit results, with an aging counter that guarantees FIFO progress.
module rf_write_arbiter #(
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_hold,
  input  logic              llu_valid,
  input  logic [4:0]        llu_rd,
  input  logic [DATA_W-1:0] llu_data,
  output logic              llu_ready,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_wsrc,
  input  logic [4:0]        Rn,
  input  logic [4:0]        Rm,
  output logic              readwrite1,
  output logic              readwrite2,
  output logic [31:0]       llu_pending
);

  localparam int                  PTR_W      = $clog2(DEPTH);
  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [4:0]          XZR        = 5'd31;

  logic [4:0]          fifo_rd   [DEPTH];
  logic [DATA_W-1:0]   fifo_data [DEPTH];
  logic [DEPTH-1:0]    valid;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [STARVE_W-1:0] starve_cnt;

  logic wb_req;
  logic q_req;
  logic push;
  logic pop;

  // Reset gates the WB request so nothing is written while reset is held.
  assign wb_req    = reset & wb_regwrite & (wb_rd != XZR);
  assign q_req     = valid[rd_ptr];
  // Full exactly when the write slot is still occupied; a same-cycle pop is not credited.
  assign llu_ready = ~valid[wr_ptr];
  assign push      = llu_valid & llu_ready & (llu_rd != XZR);

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the block leaves a value unassigned and infers a latch.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_wsrc  = 1'b0;
    wb_hold  = 1'b0;
    pop      = 1'b0;
    if (q_req && (!wb_req || starve_cnt >= STARVE_MAX)) begin
      rf_we    = 1'b1;
      rf_waddr = fifo_rd[rd_ptr];
      rf_wdata = fifo_data[rd_ptr];
      rf_wsrc  = 1'b1;
      wb_hold  = wb_req;
      pop      = 1'b1;
    end else if (wb_req) begin
      rf_we    = 1'b1;
      rf_waddr = wb_rd;
      rf_wdata = wb_data;
    end
  end

  assign readwrite1 = rf_we & (rf_waddr == Rn);
  assign readwrite2 = rf_we & (rf_waddr == Rm);

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop || !q_req)
        starve_cnt <= '0;
      else if (wb_req)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // NOTE: payload storage has no reset; the valid bits alone decide whether a slot
  // is meaningful, so clearing the data would only cost reset routing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= llu_rd;
      fifo_data[wr_ptr] <= llu_data;
    end
  end

  always_comb begin
    llu_pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i]) llu_pending[fifo_rd[i]] = 1'b1;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_rf_write_arbiter;

  localparam int DATA_W       = 64;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_regwrite;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_hold;
  logic              llu_valid;
  logic [4:0]        llu_rd;
  logic [DATA_W-1:0] llu_data;
  logic              llu_ready;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_wsrc;
  logic [4:0]        Rn;
  logic [4:0]        Rm;
  logic              readwrite1;
  logic              readwrite2;
  logic [31:0]       llu_pending;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .wb_hold(wb_hold),
    .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data), .llu_ready(llu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wsrc(rf_wsrc),
    .Rn(Rn), .Rm(Rm), .readwrite1(readwrite1), .readwrite2(readwrite2),
    .llu_pending(llu_pending)
  );

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: the FIFO is a plain queue, aging is an integer count.
  ent_t mq[$];
  int   starve;
  int   checks = 0;
  int   errors = 0;

  logic              exp_we, exp_src, exp_hold, exp_ready, exp_rw1, exp_rw2;
  logic [4:0]        exp_waddr;
  logic [DATA_W-1:0] exp_wdata;
  logic [31:0]       exp_pend;

  function automatic void model_eval();
    bit wb_req, take_q;
    wb_req    = reset && wb_regwrite && (wb_rd != 5'd31);
    take_q    = (mq.size() > 0) && (!wb_req || starve >= STARVE_LIMIT);
    exp_we    = take_q || wb_req;
    exp_src   = take_q;
    exp_hold  = take_q && wb_req;
    exp_waddr = take_q ? mq[0].rd : (wb_req ? wb_rd : 5'd0);
    exp_wdata = take_q ? mq[0].data : (wb_req ? wb_data : '0);
    exp_ready = mq.size() < DEPTH;
    exp_pend  = '0;
    foreach (mq[i]) exp_pend[mq[i].rd] = 1'b1;
    exp_rw1   = exp_we && (exp_waddr == Rn);
    exp_rw2   = exp_we && (exp_waddr == Rm);
  endfunction

  function automatic void model_advance();
    bit accept;
    model_eval();
    if (!reset) begin
      mq.delete();
      starve = 0;
      return;
    end
    accept = llu_valid && exp_ready && (llu_rd != 5'd31);
    if (exp_src) begin
      mq.delete(0);
      starve = 0;
    end else if (mq.size() == 0) begin
      starve = 0;
    end else if (exp_we) begin
      starve++;
    end
    if (accept) mq.push_back('{rd: llu_rd, data: llu_data});
  endfunction

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
    Rn = '0; Rm = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 64'h33;
    repeat (2) tick();
    checks++;
    if ({rf_we, wb_hold, llu_ready, llu_pending} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: we/hold/ready/pend got %b %b %b %h want 0 0 1 0",
               rf_we, wb_hold, llu_ready, llu_pending);
    end
    reset = 1'b1;
    llu_valid = 1'b1; llu_rd = 5'd1; llu_data = 64'h11;
    #1; tick();
    llu_rd = 5'd2; llu_data = 64'h22;
    #1; tick();
    llu_valid = 1'b0;
    #1;
    checks++;
    if (llu_pending !== 32'h6 || llu_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_prefill: pend %h ready %b want 00000006 0", llu_pending, llu_ready);
    end
    reset = 1'b0;
    mq.delete(); starve = 0;
    #1;
    checks++;
    if ({rf_we, wb_hold, llu_ready, llu_pending, readwrite1, readwrite2} !==
        {1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midop: we/hold/ready/pend/rw got %b %b %b %h %b%b want 0 0 1 0 00",
               rf_we, wb_hold, llu_ready, llu_pending, readwrite1, readwrite2);
    end
    tick();
    reset = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if ({rf_we, llu_ready, llu_pending} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset_release: we/ready/pend got %b %b %h want 0 1 0", rf_we, llu_ready, llu_pending);
    end
  endtask

  task automatic test_llu_basic();
    idle_inputs();
    llu_valid = 1'b1; llu_rd = 5'd5; llu_data = 64'hAA;
    #1;
    checks++;
    if (llu_ready !== 1'b1 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL llu_accept: ready %b we %b want 1 0", llu_ready, rf_we);
    end
    tick();
    llu_valid = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, rf_wsrc, llu_pending[5]} !==
        {1'b1, 5'd5, 64'hAA, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL llu_write: we %b addr %0d data %h src %b pend5 %b want 1 5 aa 1 1",
               rf_we, rf_waddr, rf_wdata, rf_wsrc, llu_pending[5]);
    end
    tick();
    checks++;
    if (llu_pending !== 32'h0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL llu_drained: pend %h we %b want 0 0", llu_pending, rf_we);
    end
  endtask

  task automatic test_starvation();
    idle_inputs();
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 64'h3333;
    llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 64'h77;
    #1; tick();
    llu_valid = 1'b0;
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      #1;
      checks++;
      if ({rf_we, rf_wsrc, rf_waddr, wb_hold} !== {1'b1, 1'b0, 5'd3, 1'b0}) begin
        errors++;
        $display("FAIL starve_wb_win[%0d]: we %b src %b addr %0d hold %b want 1 0 3 0",
                 k, rf_we, rf_wsrc, rf_waddr, wb_hold);
      end
      tick();
    end
    checks++;
    if ({rf_we, rf_wsrc, rf_waddr, rf_wdata, wb_hold} !== {1'b1, 1'b1, 5'd7, 64'h77, 1'b1}) begin
      errors++;
      $display("FAIL starve_forced: we %b src %b addr %0d data %h hold %b want 1 1 7 77 1",
               rf_we, rf_wsrc, rf_waddr, rf_wdata, wb_hold);
    end
    tick();
    checks++;
    if ({rf_we, rf_wsrc, rf_waddr, rf_wdata, wb_hold} !== {1'b1, 1'b0, 5'd3, 64'h3333, 1'b0}) begin
      errors++;
      $display("FAIL starve_retry: we %b src %b addr %0d data %h hold %b want 1 0 3 3333 0",
               rf_we, rf_wsrc, rf_waddr, rf_wdata, wb_hold);
    end
  endtask

  task automatic test_full_backpressure();
    bit         found;
    logic [4:0] got_rd;
    idle_inputs();
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 64'h3333;
    llu_valid = 1'b1; llu_rd = 5'd1; llu_data = 64'h101;
    #1; tick();
    llu_rd = 5'd2; llu_data = 64'h202;
    #1; tick();
    llu_rd = 5'd4; llu_data = 64'h404;
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      #1;
      checks++;
      if (llu_ready !== 1'b0 || rf_wsrc !== (k == STARVE_LIMIT - 1) ||
          (k == STARVE_LIMIT - 1 && rf_waddr !== 5'd1)) begin
        errors++;
        $display("FAIL full_hold[%0d]: ready %b src %b addr %0d", k, llu_ready, rf_wsrc, rf_waddr);
      end
      tick();
    end
    checks++;
    if (llu_ready !== 1'b1 || llu_pending !== 32'h4) begin
      errors++;
      $display("FAIL full_reopen: ready %b pend %h want 1 00000004", llu_ready, llu_pending);
    end
    tick();
    llu_valid = 1'b0;
    found = 1'b0;
    got_rd = '0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (rf_wsrc === 1'b1) begin
        found = 1'b1;
        got_rd = rf_waddr;
      end
      tick();
    end
    checks++;
    if (!found || got_rd !== 5'd2) begin
      errors++;
      $display("FAIL full_drain_second: found %b rd %0d want 1 2", found, got_rd);
    end
    wb_regwrite = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_wsrc, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd4, 64'h404}) begin
      errors++;
      $display("FAIL full_drain_third: we %b src %b addr %0d data %h want 1 1 4 404",
               rf_we, rf_wsrc, rf_waddr, rf_wdata);
    end
    repeat (2) tick();
  endtask

  task automatic test_xzr();
    idle_inputs();
    wb_regwrite = 1'b1; wb_rd = 5'd31; wb_data = 64'hDEAD;
    llu_valid = 1'b1; llu_rd = 5'd31; llu_data = 64'hBEEF;
    Rn = 5'd31; Rm = 5'd31;
    #1;
    checks++;
    if ({rf_we, wb_hold, llu_ready, llu_pending, readwrite1, readwrite2} !==
        {1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL xzr_now: we/hold/ready/pend/rw %b %b %b %h %b%b want 0 0 1 0 00",
               rf_we, wb_hold, llu_ready, llu_pending, readwrite1, readwrite2);
    end
    tick();
    llu_valid = 1'b0; wb_regwrite = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b0 || llu_pending !== 32'h0) begin
      errors++;
      $display("FAIL xzr_not_enqueued: we %b pend %h want 0 0", rf_we, llu_pending);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    wb_regwrite = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
    Rn = 5'd9; Rm = 5'd4;
    #1;
    checks++;
    if ({readwrite1, readwrite2} !== 2'b10) begin
      errors++;
      $display("FAIL bypass_rn: rw1 %b rw2 %b want 1 0", readwrite1, readwrite2);
    end
    Rm = 5'd9;
    #1;
    checks++;
    if ({readwrite1, readwrite2} !== 2'b11) begin
      errors++;
      $display("FAIL bypass_both: rw1 %b rw2 %b want 1 1", readwrite1, readwrite2);
    end
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_random();
    logic [106:0] got, want;
    for (int n = 0; n < 500; n++) begin
      wb_regwrite = ($urandom_range(0, 3) != 0);
      wb_rd       = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      wb_data     = {$urandom, $urandom};
      llu_valid   = ($urandom_range(0, 2) == 0);
      llu_rd      = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      llu_data    = {$urandom, $urandom};
      Rn          = 5'($urandom_range(0, 7));
      Rm          = 5'($urandom_range(0, 7));
      reset       = ($urandom_range(0, 99) != 0);
      if (!reset) begin
        mq.delete();
        starve = 0;
      end
      #1;
      model_eval();
      got  = {rf_we, rf_wsrc, wb_hold, llu_ready, readwrite1, readwrite2,
              rf_waddr, llu_pending, rf_wdata};
      want = {exp_we, exp_src, exp_hold, exp_ready, exp_rw1, exp_rw2,
              exp_waddr, exp_pend, exp_wdata};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random[%0d] we,src,hold,ready,rw1,rw2,addr,pend,data: got %h want %h",
                 n, got, want);
      end
      tick();
    end
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    starve = 0;
    test_reset();
    test_llu_basic();
    test_starvation();
    test_full_backpressure();
    test_xzr();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
